// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin arbiter and sequencer sharing one signed shift-add multiplier between two requesters.
// Optional feature: define MULTCTRL_ZERO_SKIP_EN to fold the shift into ADD when M=0 on non-final iterations.
module mult_share_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic REQ0,
    input  logic REQ1,
    input  logic M,
    output logic GNT0,
    output logic GNT1,
    output logic DONE0,
    output logic DONE1,
    output logic OPSEL,
    output logic BUSY,
    output logic CLEARXA,
    output logic LOADB,
    output logic LOADA,
    output logic LOADX,
    output logic SUBADD,
    output logic SHIFT_EN
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADD, S_SHIFT, S_DONE, S_RELEASE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ptr_q, ptr_d;
    logic opsel_q, opsel_d;
    logic last;
    assign last  = cnt_q == LAST;
    assign BUSY  = state_q != S_IDLE;
    assign GNT0  = BUSY & ~opsel_q;
    assign GNT1  = BUSY & opsel_q;
    assign OPSEL = opsel_q;
    // State, iteration count, last-served pointer and operand select; pointer starts at 1 so requester 0 wins first
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            opsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            opsel_q <= opsel_d;
        end
    end
    // Next-state, arbitration and datapath control decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        opsel_d  = opsel_q;
        DONE0    = 1'b0;
        DONE1    = 1'b0;
        CLEARXA  = 1'b0;
        LOADB    = 1'b0;
        LOADA    = 1'b0;
        LOADX    = 1'b0;
        SUBADD   = 1'b0;
        SHIFT_EN = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQ0 | REQ1) begin
                    opsel_d = (REQ0 & REQ1) ? ~ptr_q : REQ1;
                    ptr_d   = opsel_d;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                CLEARXA = 1'b1;
                LOADB   = 1'b1;
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
`ifdef MULTCTRL_ZERO_SKIP_EN
                if (!M && !last) begin
                    SHIFT_EN = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else begin
                    LOADA   = M;
                    LOADX   = M;
                    SUBADD  = M & last;
                    state_d = S_SHIFT;
                end
`else
                LOADA   = M;
                LOADX   = M;
                SUBADD  = M & last;
                state_d = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                SHIFT_EN = 1'b1;
                cnt_d    = last ? cnt_q : cnt_q + 1'b1;
                state_d  = last ? S_DONE : S_ADD;
            end
            S_DONE: begin
                DONE0   = ~opsel_q;
                DONE1   = opsel_q;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!(opsel_q ? REQ1 : REQ0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
